// File: rtl/warp_fetch_scheduler.sv
// Round-robin warp picker feeding a single-entry fetch register with valid/ready handshake.
// Define WARP_FETCH_SCHED_PERF_EN to add saturating issue/stall performance counters.
module warp_fetch_scheduler #(
    parameter int NumWarps     = 32,
    parameter int WarpWidth    = 32,
    parameter int PcWidth      = 32,
    parameter int PerfCntWidth = 32,
    parameter int WidWidth     = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          sched_en_i,
    input  logic [NumWarps-1:0]           warp_ready_i,
    input  logic [NumWarps*PcWidth-1:0]   warp_pc_i,
    input  logic [NumWarps*WarpWidth-1:0] warp_act_mask_i,
    output logic [NumWarps-1:0]           warp_selected_o,
    output logic                          fetch_valid_o,
    input  logic                          fetch_ready_i,
    output logic [WidWidth-1:0]           fetch_wid_o,
    output logic [PcWidth-1:0]            fetch_pc_o,
    output logic [WarpWidth-1:0]          fetch_act_mask_o,
    output logic [PerfCntWidth-1:0]       perf_issued_o,
    output logic [PerfCntWidth-1:0]       perf_stall_o
);

    localparam int ScanW = WidWidth + 1;

    logic [WidWidth-1:0]  rr_q;
    logic [WidWidth-1:0]  grant;
    logic [ScanW-1:0]     scan_idx;
    logic                 found;
    logic                 load;
    logic [PcWidth-1:0]   sel_pc;
    logic [WarpWidth-1:0] sel_mask;

    // Rotating priority scan starting at rr_q; wrap by subtraction since rr_q < NumWarps.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NumWarps; i++) begin
            scan_idx = {1'b0, rr_q} + ScanW'(i);
            if (scan_idx >= ScanW'(NumWarps)) begin
                scan_idx = scan_idx - ScanW'(NumWarps);
            end
            if (!found && warp_ready_i[scan_idx[WidWidth-1:0]]) begin
                found = 1'b1;
                grant = scan_idx[WidWidth-1:0];
            end
        end
    end

    always_comb begin
        sel_pc   = '0;
        sel_mask = '0;
        for (int i = 0; i < NumWarps; i++) begin
            if (grant == WidWidth'(i)) begin
                sel_pc   = warp_pc_i[i*PcWidth +: PcWidth];
                sel_mask = warp_act_mask_i[i*WarpWidth +: WarpWidth];
            end
        end
    end

    assign load = !rst_i && sched_en_i && found && (!fetch_valid_o || fetch_ready_i);

    always_comb begin
        warp_selected_o = '0;
        if (load) begin
            warp_selected_o[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_valid_o    <= 1'b0;
            fetch_wid_o      <= '0;
            fetch_pc_o       <= '0;
            fetch_act_mask_o <= '0;
            rr_q             <= '0;
        end else if (load) begin
            fetch_valid_o    <= 1'b1;
            fetch_wid_o      <= grant;
            fetch_pc_o       <= sel_pc;
            fetch_act_mask_o <= sel_mask;
            rr_q             <= (grant == WidWidth'(NumWarps - 1)) ? '0 : grant + WidWidth'(1);
        end else if (fetch_valid_o && fetch_ready_i) begin
            fetch_valid_o    <= 1'b0;
        end
    end

`ifdef WARP_FETCH_SCHED_PERF_EN
    logic [PerfCntWidth-1:0] issued_q;
    logic [PerfCntWidth-1:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (fetch_valid_o && fetch_ready_i && issued_q != '1) begin
                issued_q <= issued_q + PerfCntWidth'(1);
            end
            if (fetch_valid_o && !fetch_ready_i && stall_q != '1) begin
                stall_q <= stall_q + PerfCntWidth'(1);
            end
        end
    end

    assign perf_issued_o = issued_q;
    assign perf_stall_o  = stall_q;
`else
    assign perf_issued_o = '0;
    assign perf_stall_o  = '0;
`endif

`ifndef SYNTHESIS
    a_sel_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(warp_selected_o));
    a_sel_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        (warp_selected_o & ~warp_ready_i) == '0);
    a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        fetch_valid_o && !fetch_ready_i |=> fetch_valid_o && $stable(fetch_wid_o)
            && $stable(fetch_pc_o) && $stable(fetch_act_mask_o));
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Scoreboard bench for warp_fetch_scheduler with four warps: directed steps push expected
// fetch entries, a negedge monitor checks the output register against the queue front.
module tb_warp_fetch_scheduler;

    localparam int NW = 4;
    localparam int WW = 32;
    localparam int PW = 32;
    localparam int CW = 32;
    localparam int IW = 2;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           sched_en_i;
    logic [NW-1:0]  warp_ready_i;
    logic [NW*PW-1:0] warp_pc_i;
    logic [NW*WW-1:0] warp_act_mask_i;
    logic [NW-1:0]  warp_selected_o;
    logic           fetch_valid_o;
    logic           fetch_ready_i;
    logic [IW-1:0]  fetch_wid_o;
    logic [PW-1:0]  fetch_pc_o;
    logic [WW-1:0]  fetch_act_mask_o;
    logic [CW-1:0]  perf_issued_o;
    logic [CW-1:0]  perf_stall_o;

    always #5 clk_i = ~clk_i;

    warp_fetch_scheduler #(
        .NumWarps(NW), .WarpWidth(WW), .PcWidth(PW), .PerfCntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sched_en_i(sched_en_i),
        .warp_ready_i(warp_ready_i), .warp_pc_i(warp_pc_i),
        .warp_act_mask_i(warp_act_mask_i), .warp_selected_o(warp_selected_o),
        .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
        .fetch_wid_o(fetch_wid_o), .fetch_pc_o(fetch_pc_o),
        .fetch_act_mask_o(fetch_act_mask_o), .perf_issued_o(perf_issued_o),
        .perf_stall_o(perf_stall_o)
    );

    typedef struct packed {
        logic [IW-1:0] wid;
        logic [PW-1:0] pc;
        logic [WW-1:0] mask;
    } entry_t;

    entry_t sb[$];
    entry_t pend_entry;
    logic   pend_valid = 1'b0;
    logic   last_rst   = 1'b1;
    logic   mon_en     = 1'b0;
    int     errors     = 0;
    int     checks     = 0;

    function automatic logic [PW-1:0] exp_pc(input int w);
        return PW'(32'h20 * w);
    endfunction

    function automatic logic [WW-1:0] exp_mask(input int w);
        return (w == 2) ? 32'hFFFF_FFFF : (32'h0F0F_0000 | WW'(w));
    endfunction

    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                checks++;
                if (sb.size() != 0) begin
                    if (fetch_valid_o !== 1'b1 || fetch_wid_o !== sb[0].wid ||
                        fetch_pc_o !== sb[0].pc || fetch_act_mask_o !== sb[0].mask) begin
                        errors++;
                        $display("FAIL entry: got v=%b wid=%0d pc=%h mask=%h, want v=1 wid=%0d pc=%h mask=%h",
                                 fetch_valid_o, fetch_wid_o, fetch_pc_o, fetch_act_mask_o,
                                 sb[0].wid, sb[0].pc, sb[0].mask);
                    end
                    if (fetch_ready_i) void'(sb.pop_front());
                end else if (fetch_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_valid: got fetch_valid_o=%b, want 0 (t=%0t)", fetch_valid_o, $time);
                end
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic [NW-1:0] rdy,
                        input logic frdy, input logic [NW-1:0] exp_sel, input string name);
        @(posedge clk_i);
        #1;
        if (last_rst) sb.delete();
        if (pend_valid) sb.push_back(pend_entry);
        pend_valid   = 1'b0;
        rst_i        = r;
        sched_en_i   = en;
        warp_ready_i = rdy;
        fetch_ready_i = frdy;
        last_rst     = r;
        @(negedge clk_i);
        checks++;
        if (warp_selected_o !== exp_sel) begin
            errors++;
            $display("FAIL %s sel: got %b, want %b", name, warp_selected_o, exp_sel);
        end
        for (int w = 0; w < NW; w++) begin
            if (exp_sel[w]) begin
                pend_entry = '{wid: IW'(w), pc: exp_pc(w), mask: exp_mask(w)};
                pend_valid = 1'b1;
            end
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    initial begin
        logic [CW-1:0] exp_stall;
        logic [CW-1:0] exp_issued;
`ifdef WARP_FETCH_SCHED_PERF_EN
        exp_stall  = 5;
        exp_issued = 6;
`else
        exp_stall  = 0;
        exp_issued = 0;
`endif
        for (int w = 0; w < NW; w++) begin
            warp_pc_i[w*PW +: PW]       = exp_pc(w);
            warp_act_mask_i[w*WW +: WW] = exp_mask(w);
        end
        rst_i = 1'b1; sched_en_i = 1'b1; warp_ready_i = '1; fetch_ready_i = 1'b1;
        @(negedge clk_i);
        check_val("sel_in_reset", 64'(warp_selected_o), 64'h0);

        // Idle after reset
        step(0, 1, 4'b0000, 1, 4'b0000, "idle0");
        mon_en = 1'b1;
        check_val("rst_wid", 64'(fetch_wid_o), 64'h0);
        check_val("rst_pc", 64'(fetch_pc_o), 64'h0);
        check_val("rst_mask", 64'(fetch_act_mask_o), 64'h0);
        check_val("rst_issued", 64'(perf_issued_o), 64'h0);
        check_val("rst_stall", 64'(perf_stall_o), 64'h0);
        step(0, 1, 4'b0000, 1, 4'b0000, "idle1");
        step(0, 1, 4'b0000, 1, 4'b0000, "idle2");

        // All ready, back-to-back rotation
        step(0, 1, 4'b1111, 1, 4'b0001, "rr0");
        step(0, 1, 4'b1111, 1, 4'b0010, "rr1");
        step(0, 1, 4'b1111, 1, 4'b0100, "rr2");
        step(0, 1, 4'b1111, 1, 4'b1000, "rr3");
        step(0, 1, 4'b1111, 1, 4'b0001, "rr_wrap");
        step(0, 1, 4'b0000, 1, 4'b0000, "drain");

        // Single ready warp 2, then scan resumes at 3
        step(0, 1, 4'b0100, 1, 4'b0100, "only2");
        step(0, 1, 4'b0000, 1, 4'b0000, "only2_out");
        step(0, 1, 4'b1111, 1, 4'b1000, "after2");

        // Backpressure on warp 3 entry
        for (int k = 0; k < 5; k++) step(0, 1, 4'b1010, 0, 4'b0000, "stall");
        step(0, 1, 4'b1010, 1, 4'b0010, "release");
        check_val("perf_stall", 64'(perf_stall_o), 64'(exp_stall));
        check_val("perf_issued", 64'(perf_issued_o), 64'(exp_issued));

        // Scheduling disabled: held warp 1 drains, nothing new
        step(0, 0, 4'b1111, 0, 4'b0000, "dis_hold");
        step(0, 0, 4'b1111, 1, 4'b0000, "dis_drain");
        step(0, 0, 4'b1111, 1, 4'b0000, "dis_idle0");
        step(0, 0, 4'b1111, 1, 4'b0000, "dis_idle1");
        step(0, 1, 4'b1111, 1, 4'b0100, "reenable");

        // Reset while the warp 2 entry is held
        step(1, 1, 4'b1111, 0, 4'b0000, "mid_reset");
        step(0, 1, 4'b1111, 1, 4'b0001, "post_reset");
        check_val("post_rst_pc", 64'(fetch_pc_o), 64'h0);
        check_val("post_rst_issued", 64'(perf_issued_o), 64'h0);
        check_val("post_rst_stall", 64'(perf_stall_o), 64'h0);
        step(0, 1, 4'b0000, 1, 4'b0000, "final_drain");
        step(0, 1, 4'b0000, 1, 4'b0000, "final_idle");

        check_val("sb_empty", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
